// File: rtl/bcd_time_counter_if.sv
// Control and display bundle between the alarm-clock controller, the time keeper
// and the seven-segment refresh stage.
interface bcd_time_counter_if;
    logic        i_Run;
    logic [1:0]  i_Set_Mode;
    logic        i_Inc;
    logic        i_Dec;
    logic [15:0] o_BCD_Num;
    logic [7:0]  o_Seconds;
    logic        o_PM;
    logic        o_Sec_Tick;
    logic        o_Min_Tick;

    modport master (
        output i_Run, i_Set_Mode, i_Inc, i_Dec,
        input  o_BCD_Num, o_Seconds, o_PM, o_Sec_Tick, o_Min_Tick
    );

    modport slave (
        input  i_Run, i_Set_Mode, i_Inc, i_Dec,
        output o_BCD_Num, o_Seconds, o_PM, o_Sec_Tick, o_Min_Tick
    );
endinterface

// File: rtl/bcd_time_counter.sv
// BCD time-of-day keeper: 1 Hz prescaler, sec/min/hour counters with manual set,
// and registered display packing in 24 h or 12 h form.
module bcd_time_counter #(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter bit HOUR_24      = 1'b1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    bcd_time_counter_if.slave bus
);
    localparam int PW = $clog2(CLKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v == vmax)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        if (v == 8'h00)
            return vmax;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Internal hour is always 24 h; the 12 h view maps 00 and 12 to 12.
    function automatic logic [7:0] hour_display(input logic [7:0] h);
        logic [4:0] h_bin;
        logic [4:0] d_bin;
        h_bin = ({1'b0, h[7:4]} * 5'd10) + {1'b0, h[3:0]};
        if (h_bin == 5'd0)
            d_bin = 5'd12;
        else if (h_bin > 5'd12)
            d_bin = h_bin - 5'd12;
        else
            d_bin = h_bin;
        if (HOUR_24)
            return h;
        if (d_bin >= 5'd10)
            return {4'd1, 4'(d_bin - 5'd10)};
        return {4'd0, d_bin[3:0]};
    endfunction

    logic [PW-1:0] presc_reg, presc_next;
    logic [7:0]    sec_reg, sec_next;
    logic [7:0]    min_reg, min_next;
    logic [7:0]    hour_reg, hour_next;
    logic          sec_tick_reg, sec_tick_next;
    logic          min_tick_reg, min_tick_next;
    logic [15:0]   bcd_num_reg, bcd_num_next;
    logic [7:0]    seconds_reg, seconds_next;
    logic          pm_reg, pm_next;
    mode_e         mode;
    logic          adj_up;
    logic          adj_down;

    assign mode     = mode_e'(bus.i_Set_Mode);
    assign adj_up   = bus.i_Inc & ~bus.i_Dec;
    assign adj_down = bus.i_Dec & ~bus.i_Inc;

    always_comb begin
        presc_next    = presc_reg;
        sec_next      = sec_reg;
        min_next      = min_reg;
        hour_next     = hour_reg;
        sec_tick_next = 1'b0;
        min_tick_next = 1'b0;

        unique case (mode)
            MODE_RUN: begin
                if (bus.i_Run) begin
                    if (presc_reg == PRESC_TC) begin
                        presc_next    = '0;
                        sec_tick_next = 1'b1;
                        sec_next      = bcd_inc(sec_reg, 8'h59);
                        if (sec_reg == 8'h59) begin
                            min_tick_next = 1'b1;
                            min_next      = bcd_inc(min_reg, 8'h59);
                            if (min_reg == 8'h59)
                                hour_next = bcd_inc(hour_reg, 8'h23);
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
            end
            MODE_SET_HOUR: begin
                presc_next = '0;
                sec_next   = 8'h00;
                if (adj_up)
                    hour_next = bcd_inc(hour_reg, 8'h23);
                else if (adj_down)
                    hour_next = bcd_dec(hour_reg, 8'h23);
            end
            MODE_SET_MIN: begin
                presc_next = '0;
                sec_next   = 8'h00;
                if (adj_up)
                    min_next = bcd_inc(min_reg, 8'h59);
                else if (adj_down)
                    min_next = bcd_dec(min_reg, 8'h59);
            end
            MODE_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    // Display registers sample the counters, so they trail a counter update by one edge.
    always_comb begin
        bcd_num_next = {hour_display(hour_reg), min_reg};
        seconds_next = sec_reg;
        pm_next      = (hour_reg >= 8'h12);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            presc_reg    <= '0;
            sec_reg      <= 8'h00;
            min_reg      <= 8'h00;
            hour_reg     <= 8'h00;
            sec_tick_reg <= 1'b0;
            min_tick_reg <= 1'b0;
            bcd_num_reg  <= HOUR_24 ? 16'h0000 : 16'h1200;
            seconds_reg  <= 8'h00;
            pm_reg       <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            sec_tick_reg <= sec_tick_next;
            min_tick_reg <= min_tick_next;
            bcd_num_reg  <= bcd_num_next;
            seconds_reg  <= seconds_next;
            pm_reg       <= pm_next;
        end
    end

    assign bus.o_BCD_Num  = bcd_num_reg;
    assign bus.o_Seconds  = seconds_reg;
    assign bus.o_PM       = pm_reg;
    assign bus.o_Sec_Tick = sec_tick_reg;
    assign bus.o_Min_Tick = min_tick_reg;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: a 24 h and a 12 h instance driven in lockstep
// with CLKS_PER_SEC=4; set-mode table plus tick, wrap, pause and reset sequences.
module tb_bcd_time_counter;
    localparam int CPS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bcd_time_counter_if bus24();
    bcd_time_counter_if bus12();

    bcd_time_counter #(.CLKS_PER_SEC(CPS), .HOUR_24(1'b1)) dut24 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus24)
    );

    bcd_time_counter #(.CLKS_PER_SEC(CPS), .HOUR_24(1'b0)) dut12 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus12)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        run;
        logic        inc;
        logic        dec;
        int          reps;
        logic [15:0] exp24;
        logic [15:0] exp12;
        logic        exp_pm;
    } vec_t;

    vec_t vecs[15];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n;
    int   min_ticks;
    int   bad_spacing;
    int   ticks_seen;
    logic [7:0] sec_before;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic run, input logic inc, input logic dec);
        bus24.i_Set_Mode = mode;
        bus24.i_Run      = run;
        bus24.i_Inc      = inc;
        bus24.i_Dec      = dec;
        bus12.i_Set_Mode = mode;
        bus12.i_Run      = run;
        bus12.i_Inc      = inc;
        bus12.i_Dec      = dec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until o_Sec_Tick is seen high, bounded at 40.
    task automatic count_to_tick(output int cnt);
        cnt = 0;
        step();
        cnt++;
        while (bus24.o_Sec_Tick !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic pulse(input logic [1:0] mode, input logic inc, input logic dec);
        drive(mode, 1'b1, inc, dec);
        step();
        drive(mode, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic quick_reset();
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        //            mode   run   inc   dec  reps exp24     exp12     pm
        vecs[0]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1,  16'h2300, 16'h1100, 1'b1};
        vecs[1]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1,  16'h0000, 16'h1200, 1'b0};
        vecs[2]  = '{2'b10, 1'b0, 1'b0, 1'b1, 1,  16'h0059, 16'h1259, 1'b0};
        vecs[3]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1,  16'h0000, 16'h1200, 1'b0};
        vecs[4]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1,  16'h0000, 16'h1200, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1,  16'h0000, 16'h1200, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 1'b0, 9,  16'h0900, 16'h0900, 1'b0};
        vecs[7]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1,  16'h1000, 16'h1000, 1'b0};
        vecs[8]  = '{2'b01, 1'b0, 1'b1, 1'b0, 2,  16'h1200, 16'h1200, 1'b1};
        vecs[9]  = '{2'b01, 1'b0, 1'b1, 1'b0, 1,  16'h1300, 16'h0100, 1'b1};
        vecs[10] = '{2'b10, 1'b0, 1'b1, 1'b0, 10, 16'h1310, 16'h0110, 1'b1};
        vecs[11] = '{2'b01, 1'b0, 1'b0, 1'b1, 1,  16'h1210, 16'h1210, 1'b1};
        vecs[12] = '{2'b11, 1'b1, 1'b1, 1'b0, 1,  16'h1210, 16'h1210, 1'b1};
        vecs[13] = '{2'b00, 1'b0, 1'b1, 1'b0, 1,  16'h1210, 16'h1210, 1'b1};
        vecs[14] = '{2'b01, 1'b0, 1'b0, 1'b1, 1,  16'h1110, 16'h1110, 1'b0};

        // Reset state and first-tick latency
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #21;
        check("rst_bcd24", bus24.o_BCD_Num, 16'h0000);
        check("rst_bcd12", bus12.o_BCD_Num, 16'h1200);
        check("rst_sec", {8'h00, bus24.o_Seconds}, 16'h0000);
        check("rst_pm", {15'd0, bus24.o_PM}, 16'd0);
        check("rst_ticks", {14'd0, bus24.o_Sec_Tick, bus24.o_Min_Tick}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_to_tick(n);
        check("first_tick_edges", 16'(n), 16'd4);
        check("sec_at_tick", {8'h00, bus24.o_Seconds}, 16'h0000);
        step();
        check("sec_after_tick", {8'h00, bus24.o_Seconds}, 16'h0001);
        count_to_tick(n);
        check("tick_rest", 16'(n), 16'd3);
        count_to_tick(n);
        check("tick_spacing", 16'(n), 16'd4);
        $display("seq run_from_reset: sec=%h", bus24.o_Seconds);

        // Set-mode table
        quick_reset();
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].mode, vecs[i].run, vecs[i].inc, vecs[i].dec);
                step();
                drive(vecs[i].mode, vecs[i].run, 1'b0, 1'b0);
                step();
            end
            $display("vec %0d: mode=%b run=%b inc=%b dec=%b x%0d -> bcd24=%h bcd12=%h pm=%b",
                     i, vecs[i].mode, vecs[i].run, vecs[i].inc, vecs[i].dec, vecs[i].reps,
                     bus24.o_BCD_Num, bus12.o_BCD_Num, bus12.o_PM);
            check($sformatf("vec%0d_bcd24", i), bus24.o_BCD_Num, vecs[i].exp24);
            check($sformatf("vec%0d_bcd12", i), bus12.o_BCD_Num, vecs[i].exp12);
            check($sformatf("vec%0d_pm24", i), {15'd0, bus24.o_PM}, {15'd0, vecs[i].exp_pm});
            check($sformatf("vec%0d_pm12", i), {15'd0, bus12.o_PM}, {15'd0, vecs[i].exp_pm});
            check($sformatf("vec%0d_sec", i), {8'h00, bus24.o_Seconds}, 16'h0000);
        end

        // 23:59 rollover over 60 ticks
        quick_reset();
        pulse(2'b01, 1'b0, 1'b1);
        pulse(2'b10, 1'b0, 1'b1);
        check("preload_bcd24", bus24.o_BCD_Num, 16'h2359);
        check("preload_pm", {15'd0, bus24.o_PM}, 16'd1);
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        min_ticks   = 0;
        bad_spacing = 0;
        for (int k = 0; k < 60; k++) begin
            count_to_tick(n);
            if (n != 4) bad_spacing++;
            if (bus24.o_Min_Tick === 1'b1) min_ticks++;
        end
        check("rollover_spacing_errs", 16'(bad_spacing), 16'd0);
        check("min_tick_at_60", {15'd0, bus24.o_Min_Tick}, 16'd1);
        check("pm_before_wrap", {15'd0, bus24.o_PM}, 16'd1);
        step();
        check("min_tick_count", 16'(min_ticks), 16'd1);
        check("wrap_bcd24", bus24.o_BCD_Num, 16'h0000);
        check("wrap_bcd12", bus12.o_BCD_Num, 16'h1200);
        check("wrap_sec", {8'h00, bus24.o_Seconds}, 16'h0000);
        check("wrap_pm", {15'd0, bus24.o_PM}, 16'd0);
        $display("seq rollover: bcd24=%h sec=%h pm=%b", bus24.o_BCD_Num, bus24.o_Seconds, bus24.o_PM);

        // Leaving run mode on the terminal-count cycle suppresses the tick
        count_to_tick(n);
        step();
        step();
        step();
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        step();
        check("tc_mode_exit_tick", {15'd0, bus24.o_Sec_Tick}, 16'd0);
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        count_to_tick(n);
        check("restart_full_second", 16'(n), 16'd4);
        $display("seq mode_exit_at_tc: restart after %0d edges", n);

        // Pause mid-second
        step();
        step();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        sec_before = bus24.o_Seconds;
        ticks_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus24.o_Sec_Tick === 1'b1) ticks_seen++;
        end
        check("pause_ticks", 16'(ticks_seen), 16'd0);
        check("pause_sec", {8'h00, bus24.o_Seconds}, {8'h00, sec_before});
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        count_to_tick(n);
        check("resume_tick_edges", 16'(n), 16'd2);
        step();
        check("resume_sec", {8'h00, bus24.o_Seconds}, 16'h0002);
        $display("seq pause: sec=%h", bus24.o_Seconds);

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_sec", {8'h00, bus24.o_Seconds}, 16'h0000);
        check("async_rst_bcd12", bus12.o_BCD_Num, 16'h1200);
        check("async_rst_tick", {15'd0, bus24.o_Sec_Tick}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_to_tick(n);
        check("post_rst_tick_edges", 16'(n), 16'd4);
        $display("seq async_reset: first tick after %0d edges", n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day keeper for the alarm clock. Divides the system clock down to a 1 Hz tick and counts seconds, minutes and hours in BCD. Supports manual setting of hours and minutes. Presents the four display digits packed for the seven-segment display refresh stage that sits directly downstream.

## Interface

**Parameters**

- `CLKS_PER_SEC`, default 100_000_000: system clocks per second tick. Must be ≥ 2.
- `HOUR_24`, default 1:
  - 1 = display 00–23.
  - 0 = display 12, 01–11 with an AM/PM flag.

**Ports**

- `i_Clk`, input, 1: system clock; all state changes on the rising edge.
- `i_Rst_n`, input, 1: asynchronous, active-low reset.
- `i_Run`, input, 1: level; 1 = timekeeping enabled in run mode.
- `i_Set_Mode`, input, 2: mode select.
  - 00 = run.
  - 01 = set hours.
  - 10 = set minutes.
  - 11 = hold.
- `i_Inc`, input, 1: one-cycle pulse; increment the selected field.
- `i_Dec`, input, 1: one-cycle pulse; decrement the selected field.
- `o_BCD_Num`, output, 16: packed display digits.
  - [3:0] = minutes ones, [7:4] = minutes tens.
  - [11:8] = hours ones, [15:12] = hours tens.
- `o_Seconds`, output, 8: BCD seconds; [3:0] = ones, [7:4] = tens.
- `o_PM`, output, 1: 1 when internal hour ≥ 12. Valid in both modes.
- `o_Sec_Tick`, output, 1: one-cycle pulse on each seconds increment.
- `o_Min_Tick`, output, 1: one-cycle pulse when seconds wrap 59→00. Used by the alarm compare stage.

## Operation

**Internal state**
- Prescaler: 0..CLKS_PER_SEC-1, width $clog2(CLKS_PER_SEC).
- Counters, all BCD nibbles: sec 00–59, min 00–59, hour 00–23 (always 24 h).
- The ones digit carries into the tens digit at 9. No nibble ever holds A–F.

**Run mode** (i_Set_Mode=00, i_Run=1)
- Prescaler increments every cycle.
- At the terminal count it returns to 0 and the seconds counter increments.
- Carries cascade within the same edge:
  - sec 59→00 increments min.
  - min 59→00 increments hour.
  - hour 23→00 wraps.
- i_Inc and i_Dec are ignored.

**Paused** (i_Set_Mode=00, i_Run=0)
- Prescaler and all counters hold.

**Hold** (i_Set_Mode=11)
- Everything holds; i_Inc and i_Dec are ignored.

**Set modes** (01, 10)
- Prescaler and sec are forced to 0 every cycle while in a set mode.
- i_Inc increments the selected field with wrap, no carry to the other field:
  - min 59→00.
  - hour 23→00.
- i_Dec decrements the selected field with wrap:
  - min 00→59.
  - hour 00→23.
- i_Inc and i_Dec in the same cycle: no change.
- Returning to run mode restarts counting from sec=00 with a full second before the first tick.

**Display conversion** (registered)
- HOUR_24=1: display hour = internal hour.
- HOUR_24=0: display hour =
  - 12 for internal 00 and 12;
  - internal−12 for 13–23;
  - internal otherwise.
- In 12 h mode the hours tens nibble is 0 or 1 (a leading zero is emitted; blanking is not this block's job).

## Timing

**Reset** (asynchronous, takes effect immediately)
- Prescaler 0; sec, min, hour 00.
- o_Seconds 8'h00, o_PM 0, o_Sec_Tick 0, o_Min_Tick 0.
- o_BCD_Num:
  - 16'h0000 when HOUR_24=1.
  - 16'h1200 when HOUR_24=0.

**Second tick**
- Define cycle N as the edge at which the prescaler goes from CLKS_PER_SEC-1 to 0.
- At edge N: sec updates and o_Sec_Tick is high for one cycle.
- o_Min_Tick is high for the same cycle when sec goes 59→00.

**Output latency**
- o_BCD_Num, o_Seconds and o_PM are registered from the counters and reflect an update one cycle later (edge N+1).
- An Inc/Dec pulse sampled at edge K is visible on o_BCD_Num after edge K+1.

**Tick spacing**
- In uninterrupted run mode, ticks are exactly CLKS_PER_SEC cycles apart.

**Mode change at a tick edge**
- If i_Set_Mode leaves 00 in the same cycle the prescaler is at its terminal count, the set-mode rule wins: no increment and no tick pulse.

**Reset mid-count**
- Reset discards the partial prescaler count.
- After release, the first tick occurs exactly CLKS_PER_SEC cycles later.

## Test plan

All scenarios use CLKS_PER_SEC=4.

1. Reset, then run with HOUR_24=1 -> o_BCD_Num=16'h0000; first o_Sec_Tick on the 4th edge after reset release; o_Seconds=8'h01 one cycle later; tick spacing is 4 cycles.
2. Preload via set mode to 23:59, return to run, wait 60 ticks -> o_Min_Tick pulses once; o_BCD_Num=16'h0000; o_Seconds=8'h00; o_PM 1→0.
3. Set-minutes mode at min=00 with one i_Dec -> min=59, hour unchanged. Set-hours mode at hour=23 with one i_Inc -> 00. i_Inc and i_Dec together -> no change.
4. HOUR_24=0: set hour 00 -> display 16'h12xx, o_PM=0. Hour 12 -> 16'h12xx, o_PM=1. Hour 13 -> 16'h01xx, o_PM=1.
5. i_Run=0 for 20 cycles mid-second -> counters frozen and no ticks; resumes with the prescaler value preserved.
6. Assert i_Rst_n low asynchronously between edges during counting -> all outputs go to their reset values immediately; the first tick comes 4 cycles after release.
